// File: rtl/secded_encoder_stream_if.sv
// Stream bundle for secded_encoder_stream: data in, codeword out, injection control and word count.
// The master side drives data and controls; the slave side is the encoder.
interface secded_encoder_stream_if #(
  parameter int unsigned K = 8,
  parameter int unsigned N = 12
);
  logic         i_valid;
  logic         o_ready;
  logic [K-1:0] i_data;
  logic         o_valid;
  logic         i_ready;
  logic [N:0]   o_code;
  logic         i_inj_arm;
  logic [N:0]   i_inj_mask;
  logic         o_inj_armed;
  logic         o_inj_done;
  logic [15:0]  o_count;

  modport master (
    output i_valid, i_data, i_ready, i_inj_arm, i_inj_mask,
    input  o_ready, o_valid, o_code, o_inj_armed, o_inj_done, o_count
  );

  modport slave (
    input  i_valid, i_data, i_ready, i_inj_arm, i_inj_mask,
    output o_ready, o_valid, o_code, o_inj_armed, o_inj_done, o_count
  );
endinterface

// File: rtl/secded_encoder_stream.sv
// Streaming SECDED encoder with a registered (N+1)-bit output, word counter and an
// optional one-shot error injector built only when SECDED_ERR_INJECT_EN is defined.
function automatic int unsigned calculate_m(int unsigned k);
  int unsigned m;
  m = 1;
  while ((1 << m) < (m + k + 1)) m++;
  return m;
endfunction

module secded_encoder_stream #(
  parameter int unsigned K = 8,
  parameter int unsigned M = calculate_m(K),
  parameter int unsigned N = M + K
) (
  input  logic i_clk,
  input  logic i_rst_n,
  secded_encoder_stream_if.slave bus
);

  // Position (1..N) of data bit idx: the idx-th non-power-of-two index.
  function automatic int unsigned data_pos(int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bits whose codeword position has bit j set.
  function automatic logic [K-1:0] data_cover(int unsigned j);
    logic [K-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (((data_pos(i) >> j) & 1) != 0) c = c | (K'(1) << i);
    end
    return c;
  endfunction

  logic [N:1] ham;
  logic [N:0] inj_vec;
  logic [N:0] code_next;
  logic       accept;

  for (genvar i = 0; i < K; i++) begin : g_data
    assign ham[data_pos(i)] = bus.i_data[i];
  end

  for (genvar j = 0; j < M; j++) begin : g_check
    assign ham[1 << j] = ^(bus.i_data & data_cover(j));
  end

  // The injection mask lands after overall parity so it produces true bit errors.
  assign code_next   = {ham, ^ham} ^ inj_vec;
  assign bus.o_ready = !bus.o_valid || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_code  <= '0;
      bus.o_count <= '0;
    end else if (accept) begin
      bus.o_valid <= 1'b1;
      bus.o_code  <= code_next;
      bus.o_count <= bus.o_count + 16'd1;
    end else if (bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
  end

`ifdef SECDED_ERR_INJECT_EN
  typedef enum logic {IDLE, ARMED} inj_state_t;

  inj_state_t state;
  logic [N:0] mask;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      mask            <= '0;
      bus.o_inj_armed <= 1'b0;
      bus.o_inj_done  <= 1'b0;
    end else begin
      bus.o_inj_done <= accept && (state == ARMED);
      // A new arm wins over the accept that consumes the old mask.
      if (bus.i_inj_arm) begin
        mask            <= bus.i_inj_mask;
        state           <= ARMED;
        bus.o_inj_armed <= 1'b1;
      end else if (accept && (state == ARMED)) begin
        state           <= IDLE;
        bus.o_inj_armed <= 1'b0;
      end
    end
  end

  assign inj_vec = (state == ARMED) ? mask : '0;
`else
  logic unused_inj;

  assign unused_inj      = ^{bus.i_inj_arm, bus.i_inj_mask};
  assign inj_vec         = '0;
  assign bus.o_inj_armed = 1'b0;
  assign bus.o_inj_done  = 1'b0;
`endif

endmodule

// File: doc/secded_encoder_stream.md
# secded_encoder_stream

- Streaming SECDED encoder: the transmit-side counterpart of `hamming_secded`.
- Accepts K-bit data words on a valid/ready handshake and emits registered (n+1)-bit codewords: Hamming check bits plus one overall-parity bit.
- Sits on the write path ahead of storage or a link; the matching decoder checks and corrects the words on the read side.
- Carries a word counter and an optional one-shot error injector, used to exercise the decoder's 1-bit and 2-bit error paths.

## Interface
Parameters:
- `K`, default 8: data width.
- `M`, default `calculate_m(K)`: number of Hamming check bits. It is the smallest m with 2^m ≥ m+K+1, so K=8 gives M=4.
- `N`, default `M+K`: Hamming codeword width. The output carries N+1 bits.

Ports (clock and reset first):
- `i_clk`, input, 1: the single clock, rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_valid`, input, 1: input data is valid.
- `o_ready`, output, 1: the block can accept a word this cycle.
- `i_data`, input, K: data word to encode.
- `o_valid`, output, 1: output codeword is valid.
- `i_ready`, input, 1: the downstream block accepts the codeword.
- `o_code`, output, N+1: the codeword.
- `i_inj_arm`, input, 1: one-cycle pulse that arms error injection.
- `i_inj_mask`, input, N+1: XOR mask, sampled when `i_inj_arm` is high.
- `o_inj_armed`, output, 1: an injection is pending.
- `o_inj_done`, output, 1: one-cycle pulse when the mask has been applied.
- `o_count`, output, 16: number of words accepted, modulo 2^16.

## Operation
Codeword layout:
- Hamming positions 1..N map to `o_code[1..N]`.
- Check bit p_(2^j) sits at position 2^j. It is the even parity over every position whose index has bit j set.
- Data bit i occupies the i-th non-power-of-two position, in ascending order.
- `o_code[0]` is the even parity of `o_code[N:1]`.
- For K=8: d0→3, d1→5, d2→6, d3→7, d4→9, d5→10, d6→11, d7→12.

Handshake:
- `o_ready = !o_valid || i_ready`, combinational.
- A word is accepted when `i_valid && o_ready`.
- An output is consumed when `o_valid && i_ready`.
- While `o_valid && !i_ready`, `o_code` and `o_valid` hold stable.
- Accept and consume in the same cycle is supported: full throughput of one word per cycle.

Counter:
- On acceptance, `o_count` increments.
- It wraps from 0xFFFF to 0 with no flag.

Injection state machine (states IDLE, ARMED):
- IDLE → ARMED on `i_inj_arm`; the mask is latched.
- ARMED → IDLE on the next acceptance. The latched mask is XORed into that word's final codeword, after overall parity has been computed, and `o_inj_done` pulses for one cycle.
- `i_inj_arm` while ARMED re-latches the mask; this is the newest-wins rule.
- `i_inj_arm` in the same cycle as an acceptance while ARMED: the old mask applies to the current word, and the new mask is latched with the state staying ARMED.
- `i_inj_arm` in the same cycle as an acceptance while IDLE: the current word is unaffected, and the next word is injected.

Reset:
- `i_rst_n` low, including mid-transfer, asynchronously clears all state.
- Any held codeword is dropped and any pending injection is discarded.

## Timing
- Latency: a word accepted at edge t appears on `o_code` with `o_valid` high immediately after edge t.
- Reset values: `o_valid`=0, `o_code`=0, `o_count`=0, `o_inj_armed`=0, `o_inj_done`=0, state=IDLE.
- `o_ready` is 1 during and after reset, because it is derived from `o_valid`=0.
- `o_inj_armed` is registered: it is high the cycle after the arming pulse.
- `o_inj_done` is registered: it is high in the cycle the injected codeword first appears.
- The input-to-output data path is registered. The only combinational path is `i_ready` → `o_ready`.

## Configuration
`SECDED_ERR_INJECT_EN`:
- Defined: the injection state machine, mask register, `o_inj_armed` and `o_inj_done` behave as described above.
- Undefined: the injection logic is not built. `i_inj_arm` and `i_inj_mask` are ignored, `o_inj_armed` and `o_inj_done` are tied to 0, and codewords are always clean.
- The port list is identical in both builds.

## Test plan
All scenarios use K=8 (codeword width 13).
- Clean encode: `i_data`=0x00 → `o_code`=0x0000; 0x01 → 0x000F; 0xFF → 0x1EEE. Each appears one cycle after acceptance, and `o_count` steps 1, 2, 3.
- Backpressure: hold `i_ready`=0 for 3 cycles with `i_valid`=1. Required: `o_code` is stable, `o_ready`=0, and no word is lost or duplicated. Release: 16 consecutive words 0..15 stream at one per cycle and match the reference encoding.
- Injection, with the macro defined: arm with mask 0x0008, then send 0x01 → `o_code`=0x0007, `o_inj_done` pulses once, and the next 0x01 → 0x000F. Arm with mask 0x0006 → a double-bit error, which the decoder must flag as `o_2bit_error`.
- Re-arm collision: arm with mask A, then arm with mask B in the same cycle as an accept. Required: that word carries A, the next word carries B, and `o_inj_armed` stays 1 between them.
- Reset mid-stream: assert `i_rst_n` low while `o_valid`=1 and ARMED → outputs take their reset values in the same cycle. After release, the first word is clean and `o_count`=1.
- Counter wrap: accept 65536 words → `o_count` returns to 0.
